// File: rtl/msg_parse.sv
// msg_parse: byte-stream frame parser feeding an OPB-style register port.
// Pulls bytes from a first-word-fall-through FIFO, recognises write/read
// frames (header, address, data, [checksum], inverted-header tail), and
// raises a one-cycle OPB_WE/OPB_RE strobe with the decoded address/data.
// Optional feature macro: MSG_PARSE_CHKSUM_EN adds an XOR checksum byte
// between the data and the tail.
module msg_parse #(
  parameter int          ADDR_BYTES    = 4,
  parameter int          DATA_BYTES    = 4,
  parameter logic [15:0] TIMEOUT_TICKS = 16'd200,
  parameter logic [7:0]  WR_HDR        = 8'h5A,
  parameter logic [7:0]  RD_HDR        = 8'h5B
) (
  input  logic                    OPB_CLK,
  input  logic                    OPB_RST_N,
  input  logic                    TICK,
  output logic                    RX_FIFO_RD,
  input  logic [7:0]              RX_FIFO_DATA,
  input  logic                    RX_FIFO_EMPTY,
  output logic [8*ADDR_BYTES-1:0] OPB_ADDR,
  output logic [8*DATA_BYTES-1:0] OPB_DO,
  output logic                    OPB_WE,
  output logic                    OPB_RE,
  output logic                    ERR_VALID,
  output logic [1:0]              ERR_CODE,
  output logic [15:0]             FRAME_CNT,
  output logic [15:0]             ERR_CNT
);

  localparam int         AW     = 8 * ADDR_BYTES;
  localparam int         DW     = 8 * DATA_BYTES;
  localparam logic [1:0] A_LAST = 2'(ADDR_BYTES - 1);
  localparam logic [1:0] D_LAST = 2'(DATA_BYTES - 1);

  localparam logic [1:0] E_TAIL = 2'd1;
  localparam logic [1:0] E_TMO  = 2'd2;
`ifdef MSG_PARSE_CHKSUM_EN
  localparam logic [1:0] E_CSUM = 2'd3;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_CSUM, S_TAIL, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;         // byte index within ADDR/DATA field
  logic          wr_q, wr_d;           // latched header was a write
  logic [7:0]    hdr_q, hdr_d;
  logic [AW-1:0] addr_sr_q, addr_sr_d;
  logic [DW-1:0] data_sr_q, data_sr_d;
  logic [15:0]   tmo_q, tmo_d;
  logic [AW-1:0] addr_o_q, addr_o_d;
  logic [DW-1:0] do_o_q, do_o_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   err_cnt_q, err_cnt_d;
`ifdef MSG_PARSE_CHKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  logic pop, active, tmo_hit;

  // Only the byte-accepting states pop; DONE/ERROR leave bytes in the FIFO.
  // Gated by reset so nothing is drained while the block is held in reset.
  assign active  = (state_q == S_ADDR) || (state_q == S_DATA) ||
                   (state_q == S_CSUM) || (state_q == S_TAIL);
  assign pop     = OPB_RST_N && !RX_FIFO_EMPTY && (active || state_q == S_IDLE);
  assign tmo_hit = (TIMEOUT_TICKS != 16'd0) && TICK &&
                   (tmo_q == TIMEOUT_TICKS - 16'd1);

  // Next-state logic: byte handling, timeout, output/counter updates.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    hdr_d       = hdr_q;
    addr_sr_d   = addr_sr_q;
    data_sr_d   = data_sr_q;
    tmo_d       = tmo_q;
    addr_o_d    = addr_o_q;
    do_o_d      = do_o_q;
    err_code_d  = err_code_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
`ifdef MSG_PARSE_CHKSUM_EN
    csum_d      = csum_q;
`endif

    // A consumed byte beats a limit-reaching tick in the same cycle.
    if (active) begin
      if (pop)          tmo_d = 16'd0;
      else if (tmo_hit) begin
        state_d    = S_ERR;
        err_code_d = E_TMO;
      end else if (TICK) tmo_d = tmo_q + 16'd1;
    end else begin
      tmo_d = 16'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (pop && (RX_FIFO_DATA == WR_HDR || RX_FIFO_DATA == RD_HDR)) begin
          hdr_d     = RX_FIFO_DATA;
          wr_d      = (RX_FIFO_DATA == WR_HDR);
          cnt_d     = 2'd0;
          addr_sr_d = '0;
          data_sr_d = '0;
`ifdef MSG_PARSE_CHKSUM_EN
          csum_d    = RX_FIFO_DATA;
`endif
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (pop) begin
          addr_sr_d = AW'({addr_sr_q, RX_FIFO_DATA});
`ifdef MSG_PARSE_CHKSUM_EN
          csum_d    = csum_q ^ RX_FIFO_DATA;
`endif
          if (cnt_q == A_LAST) begin
            cnt_d   = 2'd0;
            state_d = S_DATA;
          end else begin
            cnt_d   = cnt_q + 2'd1;
          end
        end
      end
      S_DATA: begin
        if (pop) begin
          data_sr_d = DW'({data_sr_q, RX_FIFO_DATA});
`ifdef MSG_PARSE_CHKSUM_EN
          csum_d    = csum_q ^ RX_FIFO_DATA;
`endif
          if (cnt_q == D_LAST) begin
            cnt_d   = 2'd0;
`ifdef MSG_PARSE_CHKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_TAIL;
`endif
          end else begin
            cnt_d   = cnt_q + 2'd1;
          end
        end
      end
      S_CSUM: begin
`ifdef MSG_PARSE_CHKSUM_EN
        if (pop) begin
          if (RX_FIFO_DATA == csum_q) state_d = S_TAIL;
          else begin
            state_d    = S_ERR;
            err_code_d = E_CSUM;
          end
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_TAIL: begin
        if (pop) begin
          if (RX_FIFO_DATA == ~hdr_q) state_d = S_DONE;
          else begin
            state_d    = S_ERR;
            err_code_d = E_TAIL;
          end
        end
      end
      default: state_d = S_IDLE;  // DONE and ERR last one cycle
    endcase

    // Entering DONE publishes the frame; entering ERR counts the error.
    if (state_d == S_DONE) begin
      addr_o_d    = addr_sr_q;
      if (wr_q) do_o_d = data_sr_q;
      frame_cnt_d = (frame_cnt_q == 16'hFFFF) ? frame_cnt_q : frame_cnt_q + 16'd1;
    end
    if (state_d == S_ERR)
      err_cnt_d   = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
  end

  // State and datapath registers.
  always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
    if (!OPB_RST_N) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      wr_q        <= 1'b0;
      hdr_q       <= 8'd0;
      addr_sr_q   <= '0;
      data_sr_q   <= '0;
      tmo_q       <= 16'd0;
      addr_o_q    <= '0;
      do_o_q      <= '0;
      err_code_q  <= 2'd0;
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 16'd0;
`ifdef MSG_PARSE_CHKSUM_EN
      csum_q      <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      hdr_q       <= hdr_d;
      addr_sr_q   <= addr_sr_d;
      data_sr_q   <= data_sr_d;
      tmo_q       <= tmo_d;
      addr_o_q    <= addr_o_d;
      do_o_q      <= do_o_d;
      err_code_q  <= err_code_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
`ifdef MSG_PARSE_CHKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign RX_FIFO_RD = pop;
  assign OPB_ADDR   = addr_o_q;
  assign OPB_DO     = do_o_q;
  assign OPB_WE     = (state_q == S_DONE) &&  wr_q;
  assign OPB_RE     = (state_q == S_DONE) && !wr_q;
  assign ERR_VALID  = (state_q == S_ERR);
  assign ERR_CODE   = err_code_q;
  assign FRAME_CNT  = frame_cnt_q;
  assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_msg_parse.sv
// Directed bench for msg_parse: default instance (4/4 bytes) plus a 2/1-byte
// instance whose frame shape depends on MSG_PARSE_CHKSUM_EN.
module tb_msg_parse;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  logic tick = 1'b0;
  always #5 gclk = ~gclk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- DUT0: default parameters ----------------
  logic [7:0] mem0 [0:255];
  int wp0 = 0, rp0 = 0;
  logic rd0, emp0, we0, re0, ev0;
  logic [7:0] dat0;
  logic [31:0] addr0, do0;
  logic [1:0] ec0;
  logic [15:0] fc0, ecnt0;
  assign emp0 = (rp0 == wp0);
  assign dat0 = mem0[rp0[7:0]];
  always @(posedge gclk) if (rd0) rp0 <= rp0 + 1;

  msg_parse u0 (
    .OPB_CLK(gclk), .OPB_RST_N(grst_n), .TICK(tick),
    .RX_FIFO_RD(rd0), .RX_FIFO_DATA(dat0), .RX_FIFO_EMPTY(emp0),
    .OPB_ADDR(addr0), .OPB_DO(do0), .OPB_WE(we0), .OPB_RE(re0),
    .ERR_VALID(ev0), .ERR_CODE(ec0), .FRAME_CNT(fc0), .ERR_CNT(ecnt0));

  int we0_n = 0, re0_n = 0, ev0_n = 0, both0_n = 0;
  logic [31:0] cwa0 = '0, cwd0 = '0, cra0 = '0, crd0 = '0;
  always @(negedge gclk) begin
    if (we0) begin we0_n <= we0_n + 1; cwa0 <= addr0; cwd0 <= do0; end
    if (re0) begin re0_n <= re0_n + 1; cra0 <= addr0; crd0 <= do0; end
    if (ev0) ev0_n <= ev0_n + 1;
    if (we0 && re0) both0_n <= both0_n + 1;
  end

  // ---------------- DUT1: 2 address bytes, 1 data byte ----------------
  logic [7:0] mem1 [0:255];
  int wp1 = 0, rp1 = 0;
  logic rd1, emp1, we1, re1, ev1;
  logic [7:0] dat1;
  logic [15:0] addr1;
  logic [7:0] do1;
  logic [1:0] ec1;
  logic [15:0] fc1, ecnt1;
  assign emp1 = (rp1 == wp1);
  assign dat1 = mem1[rp1[7:0]];
  always @(posedge gclk) if (rd1) rp1 <= rp1 + 1;

  msg_parse #(.ADDR_BYTES(2), .DATA_BYTES(1)) u1 (
    .OPB_CLK(gclk), .OPB_RST_N(grst_n), .TICK(tick),
    .RX_FIFO_RD(rd1), .RX_FIFO_DATA(dat1), .RX_FIFO_EMPTY(emp1),
    .OPB_ADDR(addr1), .OPB_DO(do1), .OPB_WE(we1), .OPB_RE(re1),
    .ERR_VALID(ev1), .ERR_CODE(ec1), .FRAME_CNT(fc1), .ERR_CNT(ecnt1));

  int we1_n = 0, ev1_n = 0;
  logic [15:0] cwa1 = '0;
  logic [7:0]  cwd1 = '0;
  always @(negedge gclk) begin
    if (we1) begin we1_n <= we1_n + 1; cwa1 <= addr1; cwd1 <= do1; end
    if (ev1) ev1_n <= ev1_n + 1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push0(input logic [95:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      mem0[wp0[7:0]] = v[8*(n-1-i) +: 8];
      wp0++;
    end
  endtask

  task automatic push1(input logic [95:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      mem1[wp1[7:0]] = v[8*(n-1-i) +: 8];
      wp1++;
    end
  endtask

  task automatic drain();
    int i = 0;
    while ((rp0 != wp0 || rp1 != wp1) && i < 200) begin
      @(negedge gclk);
      i++;
    end
    chk("fifo_drained", 64'((rp0 == wp0) && (rp1 == wp1)), 64'd1);
    repeat (3) @(negedge gclk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge gclk) tick = 1'b1;
      @(negedge gclk) tick = 1'b0;
    end
  endtask

  initial begin
    // Reset state, with a byte waiting: no pop while in reset.
    push0(96'h00, 1);
    repeat (3) @(negedge gclk);
    chk("rst_rd",    64'(rd0),   64'd0);
    chk("rst_addr",  64'(addr0), 64'd0);
    chk("rst_do",    64'(do0),   64'd0);
    chk("rst_strb",  64'({we0, re0, ev0}), 64'd0);
    chk("rst_ecode", 64'(ec0),   64'd0);
    chk("rst_cnts",  64'({fc0, ecnt0}), 64'd0);
    grst_n = 1'b1;

    // Write frame (leading 00 is discarded in IDLE).
    push0(96'h5A12345678DEADBEEFA5, 10);
    drain();
    chk("wr_we_n",  64'(we0_n), 64'd1);
    chk("wr_addr",  64'(cwa0),  64'h12345678);
    chk("wr_do",    64'(cwd0),  64'hDEADBEEF);
    chk("wr_fcnt",  64'(fc0),   64'd1);
    chk("wr_hold",  64'(addr0), 64'h12345678);

    // Read frame: address updates, OPB_DO untouched.
    push0(96'h5B0000001011223344A4, 10);
    drain();
    chk("rd_re_n",  64'(re0_n), 64'd1);
    chk("rd_addr",  64'(cra0),  64'h00000010);
    chk("rd_do",    64'(crd0),  64'hDEADBEEF);
    chk("rd_we_n",  64'(we0_n), 64'd1);
    chk("rd_fcnt",  64'(fc0),   64'd2);

    // Garbage then a valid write.
    push0(96'h00FF, 2);
    push0(96'h5A0102030405060708A5, 10);
    drain();
    chk("gb_we_n",  64'(we0_n), 64'd2);
    chk("gb_addr",  64'(cwa0),  64'h01020304);
    chk("gb_do",    64'(cwd0),  64'h05060708);
    chk("gb_ecnt",  64'(ecnt0), 64'd0);

    // Bad tail.
    push0(96'h5A0000000000000000A4, 10);
    drain();
    chk("bt_ev_n",  64'(ev0_n), 64'd1);
    chk("bt_code",  64'(ec0),   64'd1);
    chk("bt_ecnt",  64'(ecnt0), 64'd1);
    chk("bt_we_n",  64'(we0_n + re0_n), 64'd3);
    chk("bt_fcnt",  64'(fc0),   64'd3);

    // Stall after 3 bytes; 199 ticks are not enough, the 200th times out.
    push0(96'h5A1122, 3);
    drain();
    ticks(199);
    chk("to_early", 64'(ev0_n), 64'd1);
    ticks(1);
    repeat (2) @(negedge gclk);
    chk("to_ev_n",  64'(ev0_n), 64'd2);
    chk("to_code",  64'(ec0),   64'd2);
    chk("to_ecnt",  64'(ecnt0), 64'd2);

    // Next frame parses normally; ERR_CODE holds.
    push0(96'h5AAABBCCDD01020304A5, 10);
    drain();
    chk("nx_we_n",  64'(we0_n), 64'd3);
    chk("nx_addr",  64'(cwa0),  64'hAABBCCDD);
    chk("nx_code",  64'(ec0),   64'd2);

    // Byte arriving with the limit-reaching tick wins.
    push0(96'h5AC1, 2);
    drain();
    ticks(199);
    @(negedge gclk) begin tick = 1'b1; push0(96'hC2, 1); end
    @(negedge gclk) tick = 1'b0;
    push0(96'hC3C4D1D2D3D4A5, 7);
    drain();
    chk("pr_ev_n",  64'(ev0_n), 64'd2);
    chk("pr_we_n",  64'(we0_n), 64'd4);
    chk("pr_addr",  64'(cwa0),  64'hC1C2C3C4);
    chk("pr_do",    64'(cwd0),  64'hD1D2D3D4);
    chk("pr_fcnt",  64'(fc0),   64'd5);
    chk("both_strb", 64'(both0_n), 64'd0);

    // Narrow instance.
`ifdef MSG_PARSE_CHKSUM_EN
    push1(96'h5A00047F21A5, 6);
    drain();
    chk("n_we_n",   64'(we1_n), 64'd1);
    chk("n_addr",   64'(cwa1),  64'h0004);
    chk("n_do",     64'(cwd1),  64'h7F);
    push1(96'h5A00047F22A5, 6);
    drain();
    chk("cs_ev_n",  64'(ev1_n), 64'd1);
    chk("cs_code",  64'(ec1),   64'd3);
    chk("cs_ecnt",  64'(ecnt1), 64'd1);
    chk("cs_we_n",  64'(we1_n), 64'd1);
`else
    push1(96'h5A00047FA5, 5);
    drain();
    chk("n_we_n",   64'(we1_n), 64'd1);
    chk("n_addr",   64'(cwa1),  64'h0004);
    chk("n_do",     64'(cwd1),  64'h7F);
    chk("n_fcnt",   64'(fc1),   64'd1);
    chk("n_ev_n",   64'(ev1_n), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  // Hard stop so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
